irq_sched: RTL and testbench

//  Interrupt controller/scheduler feeding the jump-control block of the 16-bit MIPS core.

---
 rtl/irq_sched.sv | 131 +++++++++++++
 tb/tb_irq_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
// Interrupt scheduler for the 16-bit MIPS core: captures request edges, applies mask and
// fixed lowest-index priority, and tracks one in-service interrupt until RET retires.
module irq_sched #(
  parameter int          N_IRQ      = 4,
  parameter logic [15:0] VEC_BASE   = 16'hF000,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [5:0]       op,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             interrupt,
  output logic [15:0]      vector_addr,
  output logic             in_service,
  output logic [2:0]       active_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  localparam logic [5:0] OP_RET = 6'b010000;

  typedef enum logic [1:0] {IDLE, FIRE, VECTOR, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [N_IRQ-1:0]   irq_prev_q;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic               interrupt_q, interrupt_d;
  logic               in_service_q, in_service_d;
  logic [2:0]         active_id_q, active_id_d;
  logic [15:0]        vector_q, vector_d;

  logic [N_IRQ-1:0]   edge_set;
  logic [N_IRQ-1:0]   eligible;
  logic [N_IRQ-1:0]   win_onehot;
  logic [N_IRQ-1:0]   clr;
  logic [2:0]         win_id;
  logic               win_valid;
  logic               is_jump;

  assign edge_set = irq_in & ~irq_prev_q;
  assign eligible = pending_q & ~mask_q;

  // Jumps and RET must not be interrupted or jump control saves a wrong return address.
  assign is_jump = (op[5:2] == 4'b0111) || (op == 6'b011000) || (op == OP_RET);

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    win_valid  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid     = 1'b1;
        win_id        = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    clr          = '0;
    interrupt_d  = 1'b0;
    in_service_d = in_service_q;
    active_id_d  = active_id_q;
    vector_d     = vector_q;
    case (state_q)
      IDLE: begin
        if (win_valid && !is_jump) begin
          clr          = win_onehot;
          interrupt_d  = 1'b1;
          in_service_d = 1'b1;
          active_id_d  = win_id;
          vector_d     = VEC_BASE + VEC_STRIDE * {13'd0, win_id};
          state_d      = FIRE;
        end
      end
      FIRE:    state_d = VECTOR;
      VECTOR:  state_d = SERVICE;
      SERVICE: begin
        if (op == OP_RET) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge overrides a same-cycle dispatch clear on the same bit.
  assign pending_d = (pending_q & ~clr) | edge_set;
  assign mask_d    = mask_we ? mask_wdata : mask_q;

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
      active_id_q  <= '0;
      vector_q     <= VEC_BASE;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      interrupt_q  <= interrupt_d;
      in_service_q <= in_service_d;
      active_id_q  <= active_id_d;
      vector_q     <= vector_d;
    end
  end

  assign interrupt   = interrupt_q;
  assign in_service  = in_service_q;
  assign active_id   = active_id_q;
  assign vector_addr = vector_q;
  assign pending     = pending_q;
  assign mask        = mask_q;

endmodule

// File: tb/tb_irq_sched.sv
// Directed testbench for irq_sched: reset, dispatch latency, priority, mask, jump blocking,
// no-nesting, mid-service reset and vector wrap-around.
module tb_irq_sched;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_RET = 6'b010000;
  localparam logic [5:0] OP_J   = 6'b011100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic [5:0]  op;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        interrupt;
  logic [15:0] vector_addr;
  logic        in_service;
  logic [2:0]  active_id;
  logic [3:0]  pending;
  logic [3:0]  mask;

  logic        w_reset;
  logic [3:0]  w_irq_in;
  logic        w_mask_we;
  logic        w_interrupt;
  logic [15:0] w_vector_addr;
  logic        w_in_service;
  logic [2:0]  w_active_id;
  logic [3:0]  w_pending;
  logic [3:0]  w_mask;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  irq_sched dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .op(op),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .interrupt(interrupt), .vector_addr(vector_addr), .in_service(in_service),
    .active_id(active_id), .pending(pending), .mask(mask)
  );

  irq_sched #(.N_IRQ(4), .VEC_BASE(16'hF000), .VEC_STRIDE(16'h2000)) u_wrap (
    .clk(clk), .reset(w_reset), .irq_in(w_irq_in), .op(OP_NOP),
    .mask_we(w_mask_we), .mask_wdata(4'h0),
    .interrupt(w_interrupt), .vector_addr(w_vector_addr), .in_service(w_in_service),
    .active_id(w_active_id), .pending(w_pending), .mask(w_mask)
  );

  // Inputs change 1 time unit after the edge and outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_service();
    op = OP_RET;
    tick();
    op = OP_NOP;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = '0; op = OP_NOP; mask_we = 1'b0; mask_wdata = '0;
    tick(); tick();
    total_cnt++; if (interrupt !== 1'b0) $display("FAIL rst_interrupt got %h want 0", interrupt); else pass_cnt++;
    total_cnt++; if (in_service !== 1'b0) $display("FAIL rst_in_service got %h want 0", in_service); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF000) $display("FAIL rst_vector got %h want F000", vector_addr); else pass_cnt++;
    total_cnt++; if (active_id !== 3'd0) $display("FAIL rst_active_id got %h want 0", active_id); else pass_cnt++;
    total_cnt++; if (pending !== 4'h0) $display("FAIL rst_pending got %h want 0", pending); else pass_cnt++;
    total_cnt++; if (mask !== 4'hF) $display("FAIL rst_mask got %h want F", mask); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    mask_we = 1'b1; mask_wdata = 4'h0;
    tick();
    mask_we = 1'b0;
    total_cnt++; if (mask !== 4'h0) $display("FAIL basic_mask got %h want 0", mask); else pass_cnt++;
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    total_cnt++; if (pending !== 4'b0100) $display("FAIL basic_pending_set got %h want 4", pending); else pass_cnt++;
    total_cnt++; if (interrupt !== 1'b0) $display("FAIL basic_early_pulse got %h want 0", interrupt); else pass_cnt++;
    tick();
    total_cnt++; if (interrupt !== 1'b1) $display("FAIL basic_pulse got %h want 1", interrupt); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF020) $display("FAIL basic_vector got %h want F020", vector_addr); else pass_cnt++;
    total_cnt++; if (active_id !== 3'd2) $display("FAIL basic_id got %h want 2", active_id); else pass_cnt++;
    total_cnt++; if (pending !== 4'h0) $display("FAIL basic_pending_clr got %h want 0", pending); else pass_cnt++;
    total_cnt++; if (in_service !== 1'b1) $display("FAIL basic_in_service got %h want 1", in_service); else pass_cnt++;
    tick();
    total_cnt++; if (interrupt !== 1'b0) $display("FAIL basic_single_pulse got %h want 0", interrupt); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF020) $display("FAIL basic_vector_hold got %h want F020", vector_addr); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (in_service !== 1'b1) $display("FAIL basic_service_hold got %h want 1", in_service); else pass_cnt++;
    finish_service();
    total_cnt++; if (in_service !== 1'b0) $display("FAIL basic_ret got %h want 0", in_service); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF020) $display("FAIL basic_vector_after_ret got %h want F020", vector_addr); else pass_cnt++;
  endtask

  task automatic test_priority();
    irq_in = 4'b1010;
    tick();
    irq_in = '0;
    tick();
    total_cnt++; if (interrupt !== 1'b1) $display("FAIL prio_pulse1 got %h want 1", interrupt); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF010) $display("FAIL prio_vector1 got %h want F010", vector_addr); else pass_cnt++;
    total_cnt++; if (active_id !== 3'd1) $display("FAIL prio_id1 got %h want 1", active_id); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (pending !== 4'b1000) $display("FAIL prio_pending3 got %h want 8", pending); else pass_cnt++;
    finish_service();
    // One IDLE cycle separates the RET from the next dispatch.
    total_cnt++; if (interrupt !== 1'b0) $display("FAIL prio_idle_gap got %h want 0", interrupt); else pass_cnt++;
    tick();
    total_cnt++; if (interrupt !== 1'b1) $display("FAIL prio_pulse2 got %h want 1", interrupt); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF030) $display("FAIL prio_vector2 got %h want F030", vector_addr); else pass_cnt++;
    total_cnt++; if (active_id !== 3'd3) $display("FAIL prio_id2 got %h want 3", active_id); else pass_cnt++;
    total_cnt++; if (pending !== 4'h0) $display("FAIL prio_pending_empty got %h want 0", pending); else pass_cnt++;
    tick(); tick();
    finish_service();
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    tick(); tick();
    total_cnt++; if (interrupt !== 1'b0) $display("FAIL mask_blocked_pulse got %h want 0", interrupt); else pass_cnt++;
    total_cnt++; if (in_service !== 1'b0) $display("FAIL mask_blocked_service got %h want 0", in_service); else pass_cnt++;
    total_cnt++; if (pending !== 4'b0001) $display("FAIL mask_pending got %h want 1", pending); else pass_cnt++;
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    total_cnt++; if (interrupt !== 1'b0) $display("FAIL mask_write_edge got %h want 0", interrupt); else pass_cnt++;
    tick();
    total_cnt++; if (interrupt !== 1'b1) $display("FAIL mask_unblock_pulse got %h want 1", interrupt); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF000) $display("FAIL mask_vector got %h want F000", vector_addr); else pass_cnt++;
    tick(); tick();
    finish_service();
  endtask

  task automatic test_jump_block();
    logic [5:0] jump_ops [6];
    jump_ops = '{6'b011100, 6'b011101, 6'b011110, 6'b011111, 6'b011000, 6'b010000};
    op = OP_J;
    irq_in = 4'b0010;
    tick();
    irq_in = '0;
    for (int k = 0; k < 6; k++) begin
      op = jump_ops[k];
      tick();
      total_cnt++; if (interrupt !== 1'b0 || in_service !== 1'b0)
        $display("FAIL jump_block op=%b got irq=%h svc=%h want 0 0", jump_ops[k], interrupt, in_service);
      else pass_cnt++;
    end
    total_cnt++; if (pending !== 4'b0010) $display("FAIL jump_pending got %h want 2", pending); else pass_cnt++;
    op = OP_NOP;
    tick();
    total_cnt++; if (interrupt !== 1'b1) $display("FAIL jump_release_pulse got %h want 1", interrupt); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF010) $display("FAIL jump_vector got %h want F010", vector_addr); else pass_cnt++;
    tick(); tick();
    finish_service();
  endtask

  task automatic test_no_nesting_and_reset();
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    tick();
    // RET during FIRE and VECTOR must not end the service.
    op = OP_RET;
    tick(); tick();
    op = OP_NOP;
    total_cnt++; if (in_service !== 1'b1) $display("FAIL nest_early_ret got %h want 1", in_service); else pass_cnt++;
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    tick(); tick();
    total_cnt++; if (interrupt !== 1'b0) $display("FAIL nest_second_pulse got %h want 0", interrupt); else pass_cnt++;
    total_cnt++; if (pending !== 4'b0001) $display("FAIL nest_pending got %h want 1", pending); else pass_cnt++;
    total_cnt++; if (active_id !== 3'd2) $display("FAIL nest_active_id got %h want 2", active_id); else pass_cnt++;
    irq_in = 4'b0010;
    reset = 1'b1;
    tick();
    total_cnt++; if (in_service !== 1'b0 || interrupt !== 1'b0)
      $display("FAIL midrst_ctrl got svc=%h irq=%h want 0 0", in_service, interrupt);
    else pass_cnt++;
    total_cnt++; if (pending !== 4'h0) $display("FAIL midrst_pending got %h want 0", pending); else pass_cnt++;
    total_cnt++; if (mask !== 4'hF) $display("FAIL midrst_mask got %h want F", mask); else pass_cnt++;
    total_cnt++; if (vector_addr !== 16'hF000 || active_id !== 3'd0)
      $display("FAIL midrst_vec_id got %h/%h want F000/0", vector_addr, active_id);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    // A line held high through reset release records exactly one edge.
    total_cnt++; if (pending !== 4'b0010) $display("FAIL held_line_edge got %h want 2", pending); else pass_cnt++;
    irq_in = '0;
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_vec;
    w_reset = 1'b1;
    tick();
    w_reset = 1'b0;
    w_mask_we = 1'b1;
    tick();
    w_mask_we = 1'b0;
    w_irq_in = 4'b1000;
    tick();
    w_irq_in = '0;
    tick();
    // 0xF000 + 3*0x2000 = 0x15000, truncated to 16 bits.
    exp_vec = 16'(32'hF000 + 32'd3 * 32'h2000);
    total_cnt++; if (w_interrupt !== 1'b1) $display("FAIL wrap_pulse got %h want 1", w_interrupt); else pass_cnt++;
    total_cnt++; if (w_vector_addr !== exp_vec) $display("FAIL wrap_vector got %h want %h", w_vector_addr, exp_vec); else pass_cnt++;
    total_cnt++; if (w_active_id !== 3'd3) $display("FAIL wrap_id got %h want 3", w_active_id); else pass_cnt++;
  endtask

  initial begin
    w_reset = 1'b1; w_irq_in = '0; w_mask_we = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_jump_block();
    test_no_nesting_and_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
